// File: rtl/pid_pkg.sv
// Shared types and helpers for the incremental PID sequencer: FSM states,
// default gain format and the 53-bit to 32-bit output clamp.
package pid_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIFF,
        S_MP,
        S_MI,
        S_MD,
        S_UPD
    } state_t;

    localparam int GW_DEF   = 16;
    localparam int FRAC_DEF = 8;
    localparam int MUL_A_W  = 34;
    localparam int PID_ACC_W = 52;

    function automatic logic signed [31:0] sat32(input logic signed [52:0] s,
                                                 input logic signed [31:0] lo,
                                                 input logic signed [31:0] hi);
        logic signed [52:0] lo_x;
        logic signed [52:0] hi_x;
        lo_x = {{21{lo[31]}}, lo};
        hi_x = {{21{hi[31]}}, hi};
        if (s > hi_x)
            return hi;
        else if (s < lo_x)
            return lo;
        else
            return s[31:0];
    endfunction

endpackage

// File: rtl/pid_seq_ctrl_if.sv
// Sample/gain/control-output bundle between the sample source and the PID
// sequencer; master drives samples and gains, slave returns u and status.
interface pid_seq_ctrl_if
    import pid_pkg::*;
#(
    parameter int GW = GW_DEF
);
    logic                 sample_valid;
    logic signed [31:0]   target;
    logic signed [31:0]   y;
    logic                 cfg_we;
    logic signed [GW-1:0] kp;
    logic signed [GW-1:0] ki;
    logic signed [GW-1:0] kd;
    logic                 ovr_clr;
    logic                 busy;
    logic signed [31:0]   u;
    logic                 u_valid;
    logic                 overrun;

    modport master (
        output sample_valid, target, y, cfg_we, kp, ki, kd, ovr_clr,
        input  busy, u, u_valid, overrun
    );

    modport slave (
        input  sample_valid, target, y, cfg_we, kp, ki, kd, ovr_clr,
        output busy, u, u_valid, overrun
    );
endinterface

// File: rtl/pid_mac.sv
// Registered signed multiply-accumulate; clr has priority over en.
module pid_mac
    import pid_pkg::*;
#(
    parameter int AW    = MUL_A_W,
    parameter int BW    = GW_DEF,
    parameter int ACC_W = PID_ACC_W
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [AW-1:0]    a_i,
    input  logic signed [BW-1:0]    b_i,
    output logic signed [ACC_W-1:0] acc_o
);
    logic signed [AW+BW-1:0]  prod;
    logic signed [ACC_W-1:0]  acc_q, acc_d;

    assign prod = a_i * b_i;

    always_comb begin
        acc_d = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (en_i)
            acc_d = acc_q + ACC_W'(prod);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/pid_seq_ctrl.sv
// Incremental PID sequencer: one shared multiplier walks the P, I and D terms,
// then u(k) = clamp(u(k-1) + du) is published with a one-cycle u_valid pulse.
module pid_seq_ctrl
    import pid_pkg::*;
#(
    parameter int                 GW    = GW_DEF,
    parameter int                 FRAC  = FRAC_DEF,
    parameter logic signed [31:0] U_MAX = 32'sh3FFFFFFF,
    parameter logic signed [31:0] U_MIN = -32'sh40000000
)(
    input logic          clk,
    input logic          rst_n,
    pid_seq_ctrl_if.slave bus
);
    state_t state_q, state_d;

    logic signed [31:0]   e0_q, e1_q, e2_q, u_q;
    logic signed [32:0]   dp_q;
    logic signed [33:0]   dd_q;
    logic signed [GW-1:0] kp_sh_q, ki_sh_q, kd_sh_q;
    logic signed [GW-1:0] kp_w_q, ki_w_q, kd_w_q;
    logic                 u_valid_q, overrun_q, overrun_d;
    logic                 accept;

    logic signed [MUL_A_W-1:0]   mac_a;
    logic signed [GW-1:0]        mac_b;
    logic                        mac_en, mac_clr;
    logic signed [PID_ACC_W-1:0] acc, acc_sh;
    logic signed [52:0]          upd_sum;

    assign accept = (state_q == S_IDLE) && bus.sample_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.sample_valid) state_d = S_DIFF;
            S_DIFF:  state_d = S_MP;
            S_MP:    state_d = S_MI;
            S_MI:    state_d = S_MD;
            S_MD:    state_d = S_UPD;
            S_UPD:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Steer the single multiplier: MP -> kp*dp, MI -> ki*e0, MD -> kd*dd.
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        case (state_q)
            S_MP: begin mac_a = {dp_q[32], dp_q};          mac_b = kp_w_q; end
            S_MI: begin mac_a = {{2{e0_q[31]}}, e0_q};     mac_b = ki_w_q; end
            S_MD: begin mac_a = dd_q;                      mac_b = kd_w_q; end
            default: ;
        endcase
    end

    assign mac_en  = state_q inside {S_MP, S_MI, S_MD};
    assign mac_clr = (state_q == S_DIFF);

    pid_mac #(.AW(MUL_A_W), .BW(GW), .ACC_W(PID_ACC_W)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (mac_a),
        .b_i   (mac_b),
        .acc_o (acc)
    );

    assign acc_sh  = acc >>> FRAC;
    assign upd_sum = {{21{u_q[31]}}, u_q} + {acc_sh[PID_ACC_W-1], acc_sh};

    // A dropped sample sets overrun even if ovr_clr is asserted that cycle.
    always_comb begin
        overrun_d = overrun_q;
        if (bus.sample_valid && (state_q != S_IDLE))
            overrun_d = 1'b1;
        else if (bus.ovr_clr)
            overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            u_valid_q <= 1'b0;
            overrun_q <= 1'b0;
            u_q       <= '0;
            e0_q      <= '0;
            e1_q      <= '0;
            e2_q      <= '0;
            dp_q      <= '0;
            dd_q      <= '0;
            kp_sh_q   <= '0;
            ki_sh_q   <= '0;
            kd_sh_q   <= '0;
            kp_w_q    <= '0;
            ki_w_q    <= '0;
            kd_w_q    <= '0;
        end else begin
            state_q   <= state_d;
            u_valid_q <= (state_q == S_UPD);
            overrun_q <= overrun_d;
            if (bus.cfg_we) begin
                kp_sh_q <= bus.kp;
                ki_sh_q <= bus.ki;
                kd_sh_q <= bus.kd;
            end
            if (accept) begin
                e0_q   <= bus.target - bus.y;
                kp_w_q <= kp_sh_q;
                ki_w_q <= ki_sh_q;
                kd_w_q <= kd_sh_q;
            end
            if (state_q == S_DIFF) begin
                dp_q <= {e0_q[31], e0_q} - {e1_q[31], e1_q};
                dd_q <= {{2{e0_q[31]}}, e0_q} - {e1_q[31], e1_q, 1'b0}
                        + {{2{e2_q[31]}}, e2_q};
            end
            if (state_q == S_UPD) begin
                u_q  <= sat32(upd_sum, U_MIN, U_MAX);
                e2_q <= e1_q;
                e1_q <= e0_q;
            end
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.u       = u_q;
    assign bus.u_valid = u_valid_q;
    assign bus.overrun = overrun_q;
endmodule
